// File: rtl/alu_operand_stage.sv
// Registered ALU operand selection between decode and execute: per-operand source
// mux (zero/PC/immediates/forwarded register) feeding an output register plus skid slot.

module alu_operand_sel #(
    parameter int XLEN   = 32,
    parameter int FWD_EN = 1,
    parameter int IS_B   = 0
) (
    input  logic [31:0]     instr,
    input  logic [XLEN-1:0] pc,
    input  logic [2:0]      src,
    input  logic [XLEN-1:0] rs_data,
    input  logic            fwd_ex_valid,
    input  logic [4:0]      fwd_ex_rd,
    input  logic [XLEN-1:0] fwd_ex_data,
    input  logic            fwd_wb_valid,
    input  logic [4:0]      fwd_wb_rd,
    input  logic [XLEN-1:0] fwd_wb_data,
    output logic [XLEN-1:0] opnd
);
    logic [4:0]      rs;
    logic [XLEN-1:0] reg_val;
    logic [63:0]     sel64;

    assign rs = (IS_B != 0) ? instr[24:20] : instr[19:15];

    always_comb begin
        reg_val = rs_data;
        if (rs == 5'd0)
            reg_val = '0;
        else if ((FWD_EN != 0) && fwd_ex_valid && (fwd_ex_rd == rs))
            reg_val = fwd_ex_data;
        else if ((FWD_EN != 0) && fwd_wb_valid && (fwd_wb_rd == rs))
            reg_val = fwd_wb_data;
    end

    // Immediates are built at 64 bits and truncated, so one form serves both XLENs.
    always_comb begin
        sel64 = '0;
        case (src)
            3'b000: sel64 = '0;
            3'b001: sel64 = 64'(pc);
            3'b010: sel64 = {{52{instr[31]}}, instr[31:20]};
            3'b011: sel64 = {{52{instr[31]}}, instr[31:25], instr[11:7]};
            3'b100: sel64 = {{32{instr[31]}}, instr[31:12], 12'b0};
            3'b101: sel64 = {{51{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            3'b110: sel64 = {{43{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default: sel64 = 64'(reg_val);
        endcase
    end

    assign opnd = sel64[XLEN-1:0];
endmodule

module alu_operand_stage #(
    parameter int XLEN   = 32,
    parameter int FWD_EN = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    input  logic [2:0]      in_src_a,
    input  logic [2:0]      in_src_b,
    input  logic [XLEN-1:0] in_rs1_data,
    input  logic [XLEN-1:0] in_rs2_data,
    input  logic            fwd_ex_valid,
    input  logic [4:0]      fwd_ex_rd,
    input  logic [XLEN-1:0] fwd_ex_data,
    input  logic            fwd_wb_valid,
    input  logic [4:0]      fwd_wb_rd,
    input  logic [XLEN-1:0] fwd_wb_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_a,
    output logic [XLEN-1:0] out_b,
    output logic [31:0]     out_instr,
    output logic [XLEN-1:0] out_pc
);
    typedef struct packed {
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic [31:0]     instr;
        logic [XLEN-1:0] pc;
    } entry_t;

    logic [1:0][2:0]      src;
    logic [1:0][XLEN-1:0] rs_data;
    logic [1:0][XLEN-1:0] opnd;
    entry_t               new_e, out_q, skid_q;
    logic                 skid_valid, accept, out_free;

    assign src     = {in_src_b, in_src_a};
    assign rs_data = {in_rs2_data, in_rs1_data};

    for (genvar g = 0; g < 2; g++) begin : g_sel
        alu_operand_sel #(.XLEN(XLEN), .FWD_EN(FWD_EN), .IS_B(g)) u_sel (
            .instr(in_instr), .pc(in_pc), .src(src[g]), .rs_data(rs_data[g]),
            .fwd_ex_valid(fwd_ex_valid), .fwd_ex_rd(fwd_ex_rd), .fwd_ex_data(fwd_ex_data),
            .fwd_wb_valid(fwd_wb_valid), .fwd_wb_rd(fwd_wb_rd), .fwd_wb_data(fwd_wb_data),
            .opnd(opnd[g])
        );
    end

    assign new_e    = '{a: opnd[0], b: opnd[1], instr: in_instr, pc: in_pc};
    assign in_ready = !skid_valid;
    assign accept   = in_valid && !skid_valid;
    assign out_free = !out_valid || out_ready;

    // Skid only fills while the output is stalled, so a full skid implies a full output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
            out_q      <= '0;
            skid_q     <= '0;
        end else if (flush) begin
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
        end else if (out_free) begin
            if (skid_valid) begin
                out_q      <= skid_q;
                out_valid  <= 1'b1;
                skid_valid <= 1'b0;
            end else if (accept) begin
                out_q     <= new_e;
                out_valid <= 1'b1;
            end else begin
                out_valid <= 1'b0;
            end
        end else if (accept) begin
            skid_q     <= new_e;
            skid_valid <= 1'b1;
        end
    end

    assign out_a     = out_q.a;
    assign out_b     = out_q.b;
    assign out_instr = out_q.instr;
    assign out_pc    = out_q.pc;
endmodule

// File: doc/alu_operand_stage.md
# alu_operand_stage

Registered operand-selection stage between decode and execute. It selects ALU operands A and B independently from zero, PC, any RV32I immediate format, or register data. Register data includes EX/WB forwarding, and every result is sign-extended to XLEN. A valid/ready handshake with a one-entry skid buffer lets execute stall without a combinational ready path back to decode.

## Interface
- XLEN, default 32: datapath width, legal values 32 or 64. Immediates and PC are sign-extended or sized to XLEN.
- FWD_EN, default 1: 1 enables the EX/WB forwarding muxes; 0 means register sources always use the rs data inputs.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous; drops all held entries.
- in_valid  in  1  decode presents an entry.
- in_ready  out  1  stage can accept; driven from registered state only.
- in_instr  in  32  raw instruction word.
- in_pc  in  XLEN  instruction address.
- in_src_a, in_src_b  in  3 each  operand source selects (encoding below).
- in_rs1_data, in_rs2_data  in  XLEN each  register-file read data.
- fwd_ex_valid  in  1  EX result available.
- fwd_ex_rd  in  5  EX destination register.
- fwd_ex_data  in  XLEN  EX result.
- fwd_wb_valid, fwd_wb_rd, fwd_wb_data  in  1/5/XLEN  same fields for WB.
- out_valid  out  1  entry valid at execute.
- out_ready  in  1  execute accepts the entry.
- out_a, out_b  out  XLEN each  selected operands.
- out_instr  out  32  instruction passed through.
- out_pc  out  XLEN  PC passed through.

## Operation
- Source encoding, identical for A and B. Immediate formats take bit 31 as sign and sign-extend to XLEN:
  - 000: zero.
  - 001: PC.
  - 010: I-imm = instr[31:20].
  - 011: S-imm = {instr[31:25], instr[11:7]}.
  - 100: U-imm = {instr[31:12], 12'b0}, sign-extended from bit 31 when XLEN=64.
  - 101: B-imm = {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
  - 110: J-imm = {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
  - 111: register. A uses rs1 = instr[19:15]; B uses rs2 = instr[24:20].
- Forwarding, applied only for source 111 when FWD_EN=1, in priority order:
  1. EX match: fwd_ex_valid and fwd_ex_rd == rs and rs != 0 → fwd_ex_data.
  2. Else WB match, same rule → fwd_wb_data.
  3. Else rsN_data.
  4. rs == 0 always yields 0, regardless of forwarding or rs data.
- Forwarding is evaluated in the accept cycle only. Entries already held are not re-forwarded; the hazard unit stalls decode when needed.
- Storage:
  - Output register (out_*) plus one skid register. in_ready = !skid_valid.
  - Accept = in_valid & in_ready.
  - On accept, the entry loads the output register if the output is empty or draining (out_valid & out_ready); otherwise it loads the skid register.
  - When the output drains and the skid register is full, the skid entry moves to the output in that same edge.
  - Entries never reorder, duplicate or drop, except on flush.
- Flush has priority over accept and drain. Next edge: out_valid=0, skid_valid=0, in_ready=1. An entry presented in the flush cycle is discarded.

## Timing
- Reset (asynchronous assert, synchronous release):
  - out_valid=0, skid_valid=0, in_ready=1.
  - out_a=0, out_b=0, out_instr=0, out_pc=0.
- Latency: accepted in cycle N → out_valid in cycle N+1 if the output was empty or draining.
- Throughput: 1 entry/cycle with out_ready held high.
- Stall: out_* held stable while out_valid & !out_ready.
- Second accept during a stall fills skid → in_ready=0 from the next cycle.
- First drain with skid full → in_ready=1 next cycle.
- No combinational path from out_ready to in_ready.
- rst_n asserted mid-operation: all entries lost immediately; outputs take reset values asynchronously.

## Test plan
- Immediates, XLEN=32: instr=0xFFF00093 with src_b=010 → out_b=0xFFFFFFFF. instr=0x800000B7 with src_b=100 → out_b=0x80000000. At XLEN=64 the same U case → out_b=0xFFFFFFFF80000000.
- B/J/S immediates:
  - instr=0xFE000EE3, src_b=101 → out_b=0xFFFFFFFC.
  - instr=0x0040006F, src_b=110 → out_b=4.
  - instr=0x00112623, src_b=011 → out_b=12.
- Forwarding, rs1=5: EX (rd=5, data=0x11) and WB (rd=5, data=0x22) both valid → out_a=0x11. EX invalid → 0x22. rs1=0 with fwd rd=0 valid → out_a=0. FWD_EN=0 → in_rs1_data.
- Backpressure: stream entries 1,2,3 with out_ready=0 for 3 cycles, then 1.
  - in_ready falls after entry 2 is accepted.
  - Outputs appear in order 1,2,3 with no loss.
  - in_ready=1 one cycle after the first drain.
- Flush with output and skid full, and in_valid=1 in the same cycle → next cycle out_valid=0, in_ready=1, presented entry discarded.
- Reset asserted mid-stream with out_valid=1 → out_valid=0 and all outputs 0 without a clock edge. After release, the first accept appears one cycle later.
